booth_result_collector: RTL and testbench

- Downstream stage of the Booth multiplier controller/datapath.
- The multiplier presents its 2N-bit product over two cycles on a shared N-bit bus, qualified by done and sel. This block captures both halves and assembles the full product.
- Products are buffered in a 2-entry FIFO and offered to the consumer with a valid/ready handshake.
- Back-pressure (mult_ready) gates the next multiplier start.

---
 rtl/booth_result_collector.sv | 101 ++++++++++
 tb/tb_booth_result_collector.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/booth_result_collector.sv
// Collects the two-cycle Booth multiplier result (upper then lower half),
// assembles the 2N-bit product and buffers it in a small FIFO for the consumer.
module booth_result_collector #(
    parameter int N     = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     done,
    input  logic                     sel,
    input  logic [N-1:0]             data_in,
    output logic                     mult_ready,
    output logic                     prod_valid,
    input  logic                     prod_ready,
    output logic [2*N-1:0]           product,
    output logic                     prod_neg,
    output logic                     prod_zero,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     proto_err,
    output logic                     ovf_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, HALF} state_t;

    state_t             state;
    logic [N-1:0]       hi_reg;
    logic [2*N-1:0]     mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic               push_req, push, pop, full;

    assign full     = (count == CW'(DEPTH));
    assign push_req = (state == HALF) && done && sel;
    assign pop      = prod_valid && prod_ready;
    // A full FIFO still accepts the push when the head leaves in the same cycle.
    assign push     = push_req && (!full || pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            hi_reg    <= '0;
            proto_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (done) begin
                    if (!sel) begin
                        hi_reg <= data_in;
                        state  <= HALF;
                    end else begin
                        proto_err <= 1'b1;
                    end
                end
                HALF: begin
                    if (!done) begin
                        proto_err <= 1'b1;
                        hi_reg    <= '0;
                        state     <= IDLE;
                    end else if (sel) begin
                        state <= IDLE;
                    end else begin
                        proto_err <= 1'b1;
                        hi_reg    <= data_in;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {hi_reg, data_in};
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push_req && !push) ovf_err <= 1'b1;
        end
    end

    assign prod_valid = (count != '0);
    assign product    = prod_valid ? mem[rd_ptr] : '0;
    assign prod_neg   = product[2*N-1];
    assign prod_zero  = (product == '0);
    // The last free slot is held for the product whose upper half is already in.
    assign mult_ready = !full && !((state == HALF) && (count == CW'(DEPTH-1)));

endmodule

// File: tb/tb_booth_result_collector.sv
// Directed bench for booth_result_collector: reset, capture, FIFO fill,
// overflow, simultaneous push/pop and protocol error handling.
module tb_booth_result_collector;
    logic        clk = 1'b0;
    logic        rst;
    logic        done, sel, prod_ready;
    logic [7:0]  data_in;
    logic        mult_ready, prod_valid, prod_neg, prod_zero, proto_err, ovf_err;
    logic [15:0] product;
    logic [1:0]  count;

    int n_chk  = 0;
    int n_fail = 0;

    booth_result_collector #(.N(8), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .done(done), .sel(sel), .data_in(data_in),
        .mult_ready(mult_ready), .prod_valid(prod_valid), .prod_ready(prod_ready),
        .product(product), .prod_neg(prod_neg), .prod_zero(prod_zero),
        .count(count), .proto_err(proto_err), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        done = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    // Upper half then lower half; returns just after the push edge.
    task automatic put(input logic [7:0] hi, input logic [7:0] lo, input logic rdy_lo);
        done = 1'b1; sel = 1'b0; data_in = hi;
        step();
        sel = 1'b1; data_in = lo; prod_ready = rdy_lo;
        step();
        done = 1'b0; sel = 1'b0; prod_ready = 1'b0;
    endtask

    task automatic pop_one();
        prod_ready = 1'b1;
        step();
        prod_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0; done = 1'b0; sel = 1'b0; data_in = '0; prod_ready = 1'b0;
        step(); step();
        check("rst_valid", prod_valid, 0);
        check("rst_mready", mult_ready, 1);
        check("rst_product", product, 0);
        check("rst_neg", prod_neg, 0);
        check("rst_zero", prod_zero, 1);
        check("rst_count", count, 0);
        check("rst_errs", {proto_err, ovf_err}, 0);
        rst = 1'b1;
        step();

        // Reset mid-HALF discards the upper half; lone lower half is a protocol error
        done = 1'b1; sel = 1'b0; data_in = 8'hAB;
        step();
        rst = 1'b0; done = 1'b0;
        step();
        rst = 1'b1;
        step();
        done = 1'b1; sel = 1'b1; data_in = 8'h38;
        step();
        done = 1'b0;
        check("midrst_count", count, 0);
        check("midrst_valid", prod_valid, 0);
        check("midrst_proto", proto_err, 1);
        step();
        check("midrst_count2", count, 0);
        do_reset();

        // Single product, consumer ready
        prod_ready = 1'b1;
        done = 1'b1; sel = 1'b0; data_in = 8'hFF;
        step();
        sel = 1'b1; data_in = 8'h38;
        step();
        done = 1'b0;
        check("single_valid", prod_valid, 1);
        check("single_product", product, 16'hFF38);
        check("single_neg", prod_neg, 1);
        check("single_zero", prod_zero, 0);
        step();
        prod_ready = 1'b0;
        check("single_count", count, 0);
        check("single_empty", prod_valid, 0);

        // Zero product
        put(8'h00, 8'h00, 1'b0);
        check("zero_product", product, 0);
        check("zero_zero", prod_zero, 1);
        check("zero_neg", prod_neg, 0);
        check("zero_valid", prod_valid, 1);
        pop_one();
        check("zero_drain", count, 0);

        // Fill and back-pressure; slot reserved while second product is in flight
        put(8'h01, 8'h02, 1'b0);
        done = 1'b1; sel = 1'b0; data_in = 8'h03;
        step();
        check("half_reserve_mready", mult_ready, 0);
        sel = 1'b1; data_in = 8'h04;
        step();
        done = 1'b0;
        check("fill_count", count, 2);
        check("fill_mready", mult_ready, 0);
        check("fill_head", product, 16'h0102);
        step();
        check("fill_stable", product, 16'h0102);
        pop_one();
        check("fill_head2", product, 16'h0304);
        check("fill_mready2", mult_ready, 1);
        check("fill_count2", count, 1);
        pop_one();
        check("fill_drain", count, 0);

        // Overflow, then simultaneous push/pop at full
        put(8'h0A, 8'h0B, 1'b0);
        put(8'h03, 8'h04, 1'b0);
        check("ovf_pre_count", count, 2);
        put(8'h05, 8'h06, 1'b0);
        check("ovf_err", ovf_err, 1);
        check("ovf_count", count, 2);
        check("ovf_head", product, 16'h0A0B);
        done = 1'b1; sel = 1'b0; data_in = 8'h05;
        step();
        sel = 1'b1; data_in = 8'h06; prod_ready = 1'b1;
        #1 check("pp_popped", product, 16'h0A0B);
        step();
        done = 1'b0; prod_ready = 1'b0;
        check("pp_count", count, 2);
        check("pp_head", product, 16'h0304);
        pop_one();
        check("pp_next", product, 16'h0506);
        pop_one();
        check("pp_drain", count, 0);
        check("ovf_sticky", ovf_err, 1);

        // Protocol errors
        do_reset();
        done = 1'b1; sel = 1'b1; data_in = 8'h55;
        step();
        done = 1'b0;
        check("idle_sel1_proto", proto_err, 1);
        check("idle_sel1_count", count, 0);
        do_reset();
        done = 1'b1; sel = 1'b0; data_in = 8'h99;
        step();
        done = 1'b0;
        step();
        check("gap_proto", proto_err, 1);
        check("gap_count", count, 0);
        put(8'h12, 8'h34, 1'b0);
        check("after_err_product", product, 16'h1234);
        check("after_err_count", count, 1);
        do_reset();
        done = 1'b1; sel = 1'b0; data_in = 8'h77;
        step();
        data_in = 8'h12;
        step();
        sel = 1'b1; data_in = 8'h34;
        step();
        done = 1'b0;
        check("overwrite_proto", proto_err, 1);
        check("overwrite_product", product, 16'h1234);
        check("overwrite_ovf", ovf_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
